// File: rtl/imm_encoder.sv
// RV32 immediate encoder: packs format, opcode, register fields and immediate into an
// instruction word behind a 2-entry output buffer. Optional error counter: IMM_ENC_STATS_EN.
module imm_encoder #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [DATAWIDTH-1:0] imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 err
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    localparam int DW = DATAWIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t enc;
    logic   in_ready_q;
    logic   accept;
    logic   pop;

    // Sign-extension checks: a field is representable when every bit above it
    // matches the field's top bit.
    logic sx_i_ok;
    logic sx_b_ok;
    logic sx_j_ok;
    logic sx_u_ok;

    assign sx_i_ok = (&imm[DW-1:11]) | ~(|imm[DW-1:11]);
    assign sx_b_ok = (&imm[DW-1:12]) | ~(|imm[DW-1:12]);
    assign sx_j_ok = (&imm[DW-1:20]) | ~(|imm[DW-1:20]);
    // For DATAWIDTH == 32 this slice is a single bit and always passes.
    assign sx_u_ok = (&imm[DW-1:31]) | ~(|imm[DW-1:31]);

    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        enc.instr = 32'h0;
        enc.err   = 1'b0;
        case (fmt)
            FMT_R: begin
                enc.instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                enc.instr = {imm[11:0], rs1, funct3, rd, opcode};
                enc.err   = ~sx_i_ok;
            end
            FMT_S: begin
                enc.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc.err   = ~sx_i_ok;
            end
            FMT_B: begin
                enc.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc.err   = ~sx_b_ok | imm[0];
            end
            FMT_U: begin
                enc.instr = {imm[31:12], rd, opcode};
                enc.err   = (|imm[11:0]) | ~sx_u_ok;
            end
            FMT_J: begin
                enc.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc.err   = ~sx_j_ok | imm[0];
            end
            default: begin
                enc.instr = 32'h0;
                enc.err   = 1'b1;
            end
        endcase
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = enc;
                end
            end
            ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_d = TWO;
                        tail_d  = enc;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    2'b11: begin
                        head_d = enc;
                    end
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the two buffer entries are reset as well, because the head entry
    // drives instr/err directly and must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign instr     = head_q.instr;
    assign err       = head_q.err;

`ifdef IMM_ENC_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (pop && head_q.err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 16'h0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; builds with or without IMM_ENC_STATS_EN.
module tb_imm_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
`ifdef IMM_ENC_STATS_EN
    logic [15:0] err_cnt;
`endif

    int checks;
    int errors;

    imm_encoder #(.DATAWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err)
`ifdef IMM_ENC_STATS_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    task automatic drive_req(input vec_t v);
        fmt    = v.fmt;
        opcode = v.op;
        rd     = v.rd;
        rs1    = v.rs1;
        rs2    = v.rs2;
        funct3 = v.f3;
        funct7 = v.f7;
        imm    = v.imm;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors(input vec_t vecs[$]);
        foreach (vecs[i]) begin
            drive_req(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || instr !== vecs[i].exp_instr || err !== vecs[i].exp_err) begin
                errors++;
                $display("FAIL %s: valid=%b instr=%h err=%b, expected valid=1 instr=%h err=%b",
                         vecs[i].name, out_valid, instr, err, vecs[i].exp_instr, vecs[i].exp_err);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_req('{"idle", 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 32'h0, 1'b0});
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b instr=%h err=%b, expected 0 1 00000000 0",
                     out_valid, in_ready, instr, err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_encode();
        vec_t v[$];
        v.push_back('{"lw_i",    3'd1, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFFC12283, 1'b0});
        v.push_back('{"beq_b",   3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,        32'h00208463, 1'b0});
        v.push_back('{"lui_u",   3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123450B7, 1'b0});
        v.push_back('{"add_r",   3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0});
        v.push_back('{"sw_s",    3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0});
        run_vectors(v);
    endtask

    task automatic test_range();
        vec_t v[$];
        v.push_back('{"lui_low", 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123450B7, 1'b1});
        v.push_back('{"j_odd",   3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h002000EF, 1'b1});
        v.push_back('{"i_2048",  3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80000013, 1'b1});
        v.push_back('{"i_m2048", 3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b0});
        v.push_back('{"b_odd",   3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5,        32'h00208263, 1'b1});
        v.push_back('{"fmt7",    3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd4,        32'h00000000, 1'b1});
        run_vectors(v);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        vec_t req[4];
        logic [31:0] exp_q[$];
        int accepted;
        req[0] = '{"a", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b0};
        req[1] = '{"b", 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200113, 1'b0};
        req[2] = '{"c", 3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300193, 1'b0};
        req[3] = '{"d", 3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h00400213, 1'b0};
        accepted  = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_req(req[c]);
            if (in_ready === 1'b1) begin
                accepted++;
                exp_q.push_back(req[c].exp_instr);
            end
            tick();
            if (c >= 1) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr !== 32'h00100093) begin
                    errors++;
                    $display("FAIL stall_cycle%0d: ready=%b valid=%b instr=%h, expected 0 1 00100093",
                             c, in_ready, out_valid, instr);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != 2) begin
            errors++;
            $display("FAIL accept_count: got %0d, expected 2", accepted);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0 || instr !== exp_q[0]) begin
                errors++;
                $display("FAIL order_%0d: valid=%b instr=%h, expected valid=1 instr=%h",
                         k, out_valid, instr, (exp_q.size() != 0) ? exp_q[0] : 32'hX);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drained: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_req('{"x", 3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0, 1'b0});
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_two: ready=%b valid=%b, expected 0 1", in_ready, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b instr=%h, expected 0 1 00000000",
                     out_valid, in_ready, instr);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushed: valid=%b, expected 0", out_valid);
        end
    endtask

`ifdef IMM_ENC_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL err_cnt_reset: got %0d, expected 0", err_cnt);
        end
        drive_req('{"e", 3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1});
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
        end
        checks++;
        if (err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL err_cnt_three: got %0d, expected 3", err_cnt);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 65540; k++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (err_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL err_cnt_saturate: got %h, expected ffff", err_cnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_encode();
        test_range();
        test_backpressure();
        test_reset_mid();
`ifdef IMM_ENC_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
